// File: rtl/accumulator_pkg.sv
// accumulator_pkg: shared widths and FSM state type for the 8-bit accumulator
package accumulator_pkg;
  localparam int OPERAND_W = 8;
  localparam int COUNT_W = 4;
  localparam int RESULT_W = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
endpackage

// File: rtl/full_adder_8bits.sv
// full_adder_8bits: 8-bit adder with carry in/out
// ports: s0, s1 operands; cin carry in; sum 8-bit sum; cout carry out
module full_adder_8bits (
  input  logic [7:0] s0,
  input  logic [7:0] s1,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, s0} + {1'b0, s1} + {8'd0, cin};
endmodule

// File: rtl/accumulator_8bits.sv
// accumulator_8bits: sums count unsigned 8-bit operands into a 16-bit result
// ports: clk, rst (async high); start/count launch a job; in_valid/in_ready/in_data
// operand stream; out_valid/out_ready/result result handshake; busy when not IDLE
module accumulator_8bits
  import accumulator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [COUNT_W-1:0]   count,
  input  logic                 in_valid,
  input  logic [OPERAND_W-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RESULT_W-1:0]  result,
  output logic                 busy
);
  localparam int HI_W = RESULT_W - OPERAND_W;
  state_e                 state_q;
  logic [OPERAND_W-1:0]   acc_lo_q;
  logic [HI_W-1:0]        acc_hi_q;
  logic [COUNT_W-1:0]     rem_q;
  logic [OPERAND_W-1:0]   sum;
  logic                   cout;
  full_adder_8bits u_add (
    .s0  (acc_lo_q),
    .s1  (in_data),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign result    = {acc_hi_q, acc_lo_q};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      rem_q    <= '0;
    end else
      case (state_q)
        IDLE:
          if (start) begin
            acc_lo_q <= '0;
            acc_hi_q <= '0;
            rem_q    <= count;
            state_q  <= count == '0 ? DONE : ACCUM;
          end
        ACCUM:
          if (in_valid) begin
            acc_lo_q <= sum;
            acc_hi_q <= acc_hi_q + {{(HI_W-1){1'b0}}, cout};
            rem_q    <= rem_q - 1'b1;
            if (rem_q == COUNT_W'(1)) state_q <= DONE;
          end
        DONE:
          if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_accumulator_8bits.sv
// tb_accumulator_8bits: directed scoreboard bench for accumulator_8bits
module tb_accumulator_8bits;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [3:0]  count = 0;
  logic        in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1;
  logic [15:0] result;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];

  accumulator_8bits dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got %0h expected none", result);
      end else chk("result", result, sb.pop_front());
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [3:0] c);
    start = 1;
    count = c;
    tick();
    start = 0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1;
    in_data = d;
    tick();
    in_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t1 [3] = '{8'd200, 8'd100, 8'd50};
    #2;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_result", result, 16'd0);
    tick();
    tick();
    rst = 0;
    tick();
    // 200+100+50 = 350
    sb.push_back(16'h015E);
    start_op(3);
    chk("accum_in_ready", {15'd0, in_ready}, 16'd1);
    for (int i = 0; i < 3; i++) send(t1[i]);
    @(negedge clk);
    chk("t1_latency", {15'd0, out_valid}, 16'd1);
    tick();
    chk("t1_idle_busy", {15'd0, busy}, 16'd0);
    chk("t1_idle_out_valid", {15'd0, out_valid}, 16'd0);
    chk("t1_result_kept", result, 16'h015E);
    // 15 * 255 = 3825
    sb.push_back(16'h0EF1);
    start_op(15);
    for (int i = 0; i < 15; i++) send(8'hFF);
    @(negedge clk);
    chk("t2_out_valid", {15'd0, out_valid}, 16'd1);
    tick();
    in_valid = 1;
    in_data = 8'h55;
    tick();
    tick();
    in_valid = 0;
    chk("idle_in_valid_busy", {15'd0, busy}, 16'd0);
    chk("idle_in_valid_result", result, 16'h0EF1);
    sb.push_back(16'h0000);
    start_op(0);
    @(negedge clk);
    chk("t3_out_valid", {15'd0, out_valid}, 16'd1);
    chk("t3_in_ready", {15'd0, in_ready}, 16'd0);
    chk("t3_result", result, 16'h0000);
    tick();
    out_ready = 0;
    sb.push_back(16'h0100);
    start_op(2);
    send(8'h80);
    tick();
    send(8'h80);
    in_valid = 1;
    in_data = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", {15'd0, out_valid}, 16'd1);
      chk("t4_hold_result", result, 16'h0100);
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    start = 1;
    count = 4'd5;
    tick();
    start = 0;
    @(negedge clk);
    chk("t4_start_in_done_busy", {15'd0, busy}, 16'd0);
    tick();
    start_op(4);
    send(8'd10);
    send(8'd20);
    rst = 1;
    #1;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_in_ready", {15'd0, in_ready}, 16'd0);
    chk("abort_out_valid", {15'd0, out_valid}, 16'd0);
    chk("abort_result", result, 16'd0);
    tick();
    rst = 0;
    in_valid = 1;
    in_data = 8'd3;
    tick();
    tick();
    in_valid = 0;
    chk("post_rst_busy", {15'd0, busy}, 16'd0);
    chk("post_rst_out_valid", {15'd0, out_valid}, 16'd0);
    sb.push_back(16'd7);
    start_op(1);
    send(8'd7);
    @(negedge clk);
    chk("t5_out_valid", {15'd0, out_valid}, 16'd1);
    tick();
    // 1+2+...+9 = 45; a second start mid-job must not restart the count
    sb.push_back(16'd45);
    start_op(9);
    for (int i = 1; i <= 4; i++) send(8'(i));
    start = 1;
    count = 4'd2;
    for (int i = 5; i <= 9; i++) send(8'(i));
    start = 0;
    @(negedge clk);
    chk("t6_out_valid", {15'd0, out_valid}, 16'd1);
    tick();
    tick();
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
